// File: rtl/sub_br32bit.sv
// 32-bit ripple-borrow subtractor with registered outputs.
// The borrow chain register and debug port exist only when SUB_DEBUG_ON is defined.

module sub_br_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module sub_br32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        bo,
  output logic [31:0] diff,
  output logic        bi
`ifdef SUB_DEBUG_ON
  ,
  output logic [31:0] debug
`endif
);

  // bchain[i] is the borrow into cell i; bchain[32] is the borrow out of bit 31
  logic [32:0] bchain;
  logic [31:0] d_comb;

  assign bchain[0] = bo;

  for (genvar i = 0; i < 32; i++) begin : g_cell
    sub_br_cell u_cell (
      .a    (op1[i]),
      .b    (op2[i]),
      .bin  (bchain[i]),
      .d    (d_comb[i]),
      .bout (bchain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bi   <= 1'b0;
    end else begin
      diff <= d_comb;
      bi   <= bchain[32];
    end
  end

`ifdef SUB_DEBUG_ON
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debug <= '0;
    end else begin
      debug <= bchain[32:1];
    end
  end
`endif

endmodule

// File: tb/tb_sub_br32bit.sv
// Self-checking bench for sub_br32bit: vector table, random ops and reset corner cases.

module tb_sub_br32bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        bo;
  logic [31:0] diff;
  logic        bi;
`ifdef SUB_DEBUG_ON
  logic [31:0] debug;
`endif

  sub_br32bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op1   (op1),
    .op2   (op2),
    .bo    (bo),
    .diff  (diff),
    .bi    (bi)
`ifdef SUB_DEBUG_ON
    ,
    .debug (debug)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        bo;
    logic [31:0] exp_diff;
    logic        exp_bi;
  } vec_t;

  typedef struct {
    logic [31:0] diff;
    logic        bi;
    logic [31:0] chain;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Borrow out of bit i is set iff the low i+1 bits of op1 are below those of op2 plus bo.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    exp_t        e;
    logic [32:0] full;
    logic [32:0] mask;
    full    = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    e.diff  = full[31:0];
    e.bi    = full[32];
    for (int i = 0; i < 32; i++) begin
      mask       = (33'd1 << (i + 1)) - 33'd1;
      e.chain[i] = (({1'b0, a} & mask) < (({1'b0, b} & mask) + {32'd0, bin}));
    end
    return e;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic bin);
    op1 = a;
    op2 = b;
    bo  = bin;
    sb_q.push_back(model(a, b, bin));
  endtask

  task automatic check_out(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      total_cnt++;
      $display("FAIL %s: scoreboard empty, got diff 0x%08h", name, diff);
    end else begin
      e = sb_q.pop_front();
      chk({name, ".diff"}, diff, e.diff);
      chk({name, ".bi"}, {31'd0, bi}, {31'd0, e.bi});
`ifdef SUB_DEBUG_ON
      chk({name, ".debug"}, debug, e.chain);
`endif
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, ".diff"}, diff, 32'd0);
    chk({name, ".bi"}, {31'd0, bi}, 32'd0);
`ifdef SUB_DEBUG_ON
    chk({name, ".debug"}, debug, 32'd0);
`endif
  endtask

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{32'h7,        32'h4,        1'b0, 32'h00000003, 1'b0};
    vecs[1]  = '{32'h7,        32'h4,        1'b1, 32'h00000002, 1'b0};
    vecs[2]  = '{32'h4,        32'h7,        1'b0, 32'hFFFFFFFD, 1'b1};
    vecs[3]  = '{32'h4,        32'h7,        1'b1, 32'hFFFFFFFC, 1'b1};
    vecs[4]  = '{32'h80000007, 32'h4,        1'b0, 32'h80000003, 1'b0};
    vecs[5]  = '{32'h80000007, 32'h4,        1'b1, 32'h80000002, 1'b0};
    vecs[6]  = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'h0,        1'b1, 32'hFFFFFFFE, 1'b0};
    vecs[8]  = '{32'h0,        32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b1};
    vecs[9]  = '{32'h0,        32'h0,        1'b0, 32'h00000000, 1'b0};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0};
    vecs[11] = '{32'h80000000, 32'h1,        1'b0, 32'h7FFFFFFF, 1'b0};
    vecs[12] = '{32'h1,        32'h80000000, 1'b0, 32'h80000001, 1'b1};
    vecs[13] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 32'h55555554, 1'b0};

    rst_n = 1'b0;
    op1   = 32'hDEADBEEF;
    op2   = 32'h1;
    bo    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");

    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back table vectors, one per cycle
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].op1, vecs[i].op2, vecs[i].bo);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_diff", i), diff, vecs[i].exp_diff);
      chk($sformatf("vec%0d.tbl_bi", i), {31'd0, bi}, {31'd0, vecs[i].exp_bi});
      @(negedge clk);
    end

    for (int i = 0; i < 20; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)));
      @(posedge clk);
      #1;
      check_out($sformatf("rand%0d", i));
      @(negedge clk);
    end

    // async reset between edges with nonzero outputs
    drive(32'h4, 32'h7, 1'b1);
    @(posedge clk);
    #1;
    check_out("pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    sb_q.delete();

    @(negedge clk);
    op1 = 32'h99;
    op2 = 32'h1;
    bo  = 1'b0;
    @(posedge clk);
    #1;
    check_zero("held_reset");

    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h10, 32'h20, 1'b1);
    @(posedge clk);
    #1;
    check_out("post_reset");
    chk("post_reset.abs_diff", diff, 32'hFFFFFFEF);

    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/sub_br32bit.md
SUB_BR32BIT -- requirements
Module: sub_br32bit

Interface
REQ-001 The clock and reset policy SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Port clk SHALL be: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-004 Port op1 SHALL be: input, 32 bits, minuend, unsigned.
REQ-005 Port op2 SHALL be: input, 32 bits, subtrahend, unsigned.
REQ-006 Port bo SHALL be: input, 1 bit, borrow-in to bit 0, subtracted as weight 1.
REQ-007 Port diff SHALL be: output, 32 bits, registered difference.
REQ-008 Port bi SHALL be: output, 1 bit, registered borrow-out from bit 31.
REQ-009 Port debug SHALL be: output, 32 bits, registered per-bit borrow chain.
REQ-010 The debug port SHALL exist only when the macro SUB_DEBUG_ON is defined.
REQ-011 When SUB_DEBUG_ON is undefined, the module SHALL have no debug port and no debug logic.
REQ-012 Parameter: none; width SHALL be fixed at 32.

Function
REQ-013 The datapath SHALL be a ripple-borrow chain of 32 one-bit full-subtractor cells.
REQ-014 Bit 0 borrow-in SHALL be bo; the borrow-in of bit i SHALL be the borrow-out of bit i-1.
REQ-015 Each cell SHALL compute d[i] = a ^ b ^ bin.
REQ-016 Each cell SHALL compute bout = (~a & b) | (~(a ^ b) & bin).
REQ-017 The combinational result SHALL equal (op1 - op2 - bo) mod 2^32.
REQ-018 The borrow-out SHALL be 1 iff op1 < op2 + bo, compared as unsigned 33-bit values.
REQ-019 Operands SHALL be treated as unsigned; bit 31 SHALL get no sign or sign-magnitude interpretation.
REQ-020 No overflow flag SHALL be produced.
REQ-021 diff, bi and debug (when present) SHALL be registered on the rising clk edge.
REQ-022 Latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-023 Throughput SHALL be one operation per cycle, with no handshake and no stall.
REQ-024 debug[i] SHALL hold the borrow-out of cell i; debug[31] SHALL equal bi.
REQ-025 Boundary: op1 = op2 with bo = 1 SHALL give diff = 0xFFFFFFFF, bi = 1.
REQ-026 Boundary: op1 = 0xFFFFFFFF, op2 = 0, bo = 1 SHALL give diff = 0xFFFFFFFE, bi = 0.
REQ-027 Boundary: op1 = 0, op2 = 0xFFFFFFFF, bo = 1 SHALL give diff = 0x00000000, bi = 1.

Reset
REQ-028 While rst_n = 0, diff, bi and debug SHALL be 0, forced asynchronously without waiting for clk.
REQ-029 Reset asserted mid-stream SHALL discard any pending result.
REQ-030 After rst_n deasserts, the first rising edge SHALL capture the current inputs normally.
REQ-031 The module SHALL have no state other than the output registers.

Verification
REQ-032 op1 = 0x7, op2 = 0x4, bo = 0 -> next cycle diff = 0x00000003, bi = 0.
REQ-033 op1 = 0x7, op2 = 0x4, bo = 1 -> next cycle diff = 0x00000002, bi = 0.
REQ-034 op1 = 0x4, op2 = 0x7, bo = 0 -> next cycle diff = 0xFFFFFFFD, bi = 1.
REQ-035 op1 = 0x4, op2 = 0x7, bo = 1 -> next cycle diff = 0xFFFFFFFC, bi = 1.
REQ-036 op1 = 0x80000007, op2 = 0x4, bo = 0 -> diff = 0x80000003, bi = 0; with bo = 1 -> diff = 0x80000002, bi = 0.
REQ-037 Assert rst_n = 0 between clock edges while outputs are nonzero -> diff, bi and debug = 0 immediately.
REQ-038 Release rst_n -> the first edge's result SHALL match the current operands.
